// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the I-cache req/ready handshake and the IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetched / miss-cycle / killed-completion counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_miss_cycles_o,
  output logic [31:0] perf_kill_o
`endif
);

  // state   | meaning
  // S_FETCH | idle or issuing at r_pc; a hit completes in the issue cycle
  // S_WAIT  | miss outstanding at r_pc; result goes to IF/ID or the hold register
  // S_KILL  | miss outstanding after a redirect; result dropped, then r_pc <= r_target
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_WAIT = 2'd1, S_KILL = 2'd2} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_o;
  logic [31:0] r_hold_data;
  logic [31:0] r_target;
  logic        r_valid;
  logic        r_hold_valid;

  logic        w_can_accept;
  logic        w_req;
  logic        w_done;
  logic        w_load;
  logic [31:0] w_load_data;
  logic [31:0] w_redirect_pc;

  assign w_can_accept  = !r_valid || !stall_i;
  assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_done        = w_req && imem_ready_i;

  // Once issued, the request stays up until ready, whatever stall/redirect do.
  always_comb begin
    w_req = 1'b0;
    if (!rst) begin
      if (r_state == S_FETCH) w_req = w_can_accept && !redirect_i && !r_hold_valid;
      else                    w_req = 1'b1;
    end
  end

  always_comb begin
    w_load      = 1'b0;
    w_load_data = imem_rdata_i;
    if (!rst && !redirect_i) begin
      case (r_state)
        S_FETCH: begin
          if (r_hold_valid) begin
            w_load      = !stall_i;
            w_load_data = r_hold_data;
          end else begin
            w_load = w_done;
          end
        end
        S_WAIT:  w_load = imem_ready_i && w_can_accept;
        default: w_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc_o       <= RESET_PC;
      r_hold_data  <= NOP_INSTR;
      r_target     <= RESET_PC;
      r_valid      <= 1'b0;
      r_hold_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_instr <= w_load_data;
        r_pc_o  <= r_pc;
        r_valid <= 1'b1;
        r_pc    <= r_pc + 32'd4;
      end
      if (redirect_i) begin
        r_valid      <= 1'b0;
        r_hold_valid <= 1'b0;
        if (r_state != S_FETCH && !imem_ready_i) begin
          r_target <= w_redirect_pc;
          r_state  <= S_KILL;
        end else begin
          r_pc    <= w_redirect_pc;
          r_state <= S_FETCH;
        end
      end else begin
        case (r_state)
          S_FETCH: begin
            // A miss issue leaves IF/ID alone; WAIT drains it on the next unstalled cycle.
            if (r_hold_valid && !stall_i) r_hold_valid <= 1'b0;
            else if (w_req && !imem_ready_i) r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_ready_i) begin
              r_state <= S_FETCH;
              if (!w_can_accept) begin
                r_hold_data  <= imem_rdata_i;
                r_hold_valid <= 1'b1;
              end
            end else if (!stall_i) begin
              r_valid <= 1'b0;
            end
          end
          S_KILL: begin
            if (imem_ready_i) begin
              r_pc    <= r_target;
              r_state <= S_FETCH;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign instr_o     = r_valid ? r_instr : NOP_INSTR;
  assign pc_o        = r_pc_o;
  assign pc_plus4_o  = r_pc_o + 32'd4;
  assign valid_o     = r_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_miss;
  logic [31:0] r_perf_kill;
  logic        w_kill_done;

  assign w_kill_done = w_done && (redirect_i || r_state == S_KILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= 32'd0;
      r_perf_miss    <= 32'd0;
      r_perf_kill    <= 32'd0;
    end else begin
      if (w_load && r_perf_fetched != 32'hFFFF_FFFF) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (r_state != S_FETCH && r_perf_miss != 32'hFFFF_FFFF) r_perf_miss <= r_perf_miss + 32'd1;
      if (w_kill_done && r_perf_kill != 32'hFFFF_FFFF) r_perf_kill <= r_perf_kill + 32'd1;
    end
  end

  assign perf_fetched_o     = r_perf_fetched;
  assign perf_miss_cycles_o = r_perf_miss;
  assign perf_kill_o        = r_perf_kill;
`endif

endmodule
